// File: rtl/memory_arbiter_pkg.sv
// Shared widths, AXI constants, FSM encoding and request payload for memory_arbiter.
package memory_arbiter_pkg;

  localparam int unsigned AXI_ADDR_WIDTH   = 32;
  localparam int unsigned AXI_DATA_WIDTH   = 32;
  localparam int unsigned AXI_STROBE_WIDTH = 4;
  localparam int unsigned AXI_RESP_WIDTH   = 2;
  localparam int unsigned AXI_PROT_WIDTH   = 3;
  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned INSTR_WIDTH      = 32;

  localparam logic [AXI_PROT_WIDTH-1:0] PROT_DATA  = 3'b000;
  localparam logic [AXI_PROT_WIDTH-1:0] PROT_INSTR = 3'b100;

  localparam logic [AXI_RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_WIDTH-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [AXI_RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_WIDTH-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RD_ADDR      = 3'd1,
    ST_RD_DATA      = 3'd2,
    ST_WR_ADDR_DATA = 3'd3,
    ST_WR_RESP      = 3'd4,
    ST_DONE         = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SRC_FETCH = 2'd0,
    SRC_LOAD  = 2'd1,
    SRC_STORE = 2'd2
  } src_e;

  // Latched request payload, held stable for the whole transaction
  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0]   addr;
    logic [AXI_DATA_WIDTH-1:0]   data;
    logic [AXI_STROBE_WIDTH-1:0] strb;
  } req_t;

endpackage

// File: rtl/memory_arbiter.sv
// Shares one AXI4-Lite master between instruction fetch and load/store, one transaction at a time.
module memory_arbiter
  import memory_arbiter_pkg::*;
(
  input  logic                        CLK,
  input  logic                        RSTn,
  // AXI write address
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [AXI_PROT_WIDTH-1:0]   M_AXI_AWPROT,
  // AXI write data
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [AXI_STROBE_WIDTH-1:0] M_AXI_WSTRB,
  // AXI write response
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  input  logic [AXI_RESP_WIDTH-1:0]   M_AXI_BRESP,
  // AXI read address
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [AXI_PROT_WIDTH-1:0]   M_AXI_ARPROT,
  // AXI read data
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [AXI_RESP_WIDTH-1:0]   M_AXI_RRESP,
  // Fetch side
  input  logic [AXI_ADDR_WIDTH-1:0]   pc,
  input  logic                        pc_valid,
  output logic [INSTR_WIDTH-1:0]      instruction,
  output logic                        instruction_valid,
  // Load/store side
  input  logic [AXI_ADDR_WIDTH-1:0]   read_write_addr,
  input  logic [DATA_WIDTH-1:0]       store_data,
  input  logic [AXI_STROBE_WIDTH-1:0] store_strobe,
  input  logic                        read_enable,
  input  logic                        write_enable,
  output logic [DATA_WIDTH-1:0]       load_data,
  output logic                        read_write_valid
);

  state_e                      state_q, state_d;
  src_e                        src_q, src_d;
  req_t                        req_q, req_d;
  logic [AXI_PROT_WIDTH-1:0]   prot_q, prot_d;
  logic                        arvalid_q, arvalid_d;
  logic                        rready_q, rready_d;
  logic                        awvalid_q, awvalid_d;
  logic                        wvalid_q, wvalid_d;
  logic                        bready_q, bready_d;
  logic [INSTR_WIDTH-1:0]      instruction_q, instruction_d;
  logic [DATA_WIDTH-1:0]       load_data_q, load_data_d;
  logic                        instr_valid_q, instr_valid_d;
  logic                        rw_valid_q, rw_valid_d;

  // Response codes are deliberately not reported back to the core
  logic unused_resp;
  assign unused_resp = ^{M_AXI_BRESP, M_AXI_RRESP};

  // Next-state and next-output computation
  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    req_d         = req_q;
    prot_d        = prot_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    instruction_d = instruction_q;
    load_data_d   = load_data_q;
    instr_valid_d = 1'b0;
    rw_valid_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (write_enable) begin
          req_d.addr = read_write_addr;
          req_d.data = store_data;
          req_d.strb = store_strobe;
          src_d      = SRC_STORE;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          state_d    = ST_WR_ADDR_DATA;
        end else if (read_enable) begin
          req_d.addr = read_write_addr;
          src_d      = SRC_LOAD;
          prot_d     = PROT_DATA;
          arvalid_d  = 1'b1;
          state_d    = ST_RD_ADDR;
        end else if (pc_valid) begin
          req_d.addr = pc;
          src_d      = SRC_FETCH;
          prot_d     = PROT_INSTR;
          arvalid_d  = 1'b1;
          state_d    = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (M_AXI_RVALID && rready_q) begin
          rready_d = 1'b0;
          if (src_q == SRC_FETCH) begin
            instruction_d = M_AXI_RDATA;
            instr_valid_d = 1'b1;
          end else begin
            load_data_d = M_AXI_RDATA;
            rw_valid_d  = 1'b1;
          end
          state_d = ST_DONE;
        end
      end
      ST_WR_ADDR_DATA: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (M_AXI_BVALID && bready_q) begin
          bready_d   = 1'b0;
          rw_valid_d = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= ST_IDLE;
      src_q         <= SRC_FETCH;
      req_q         <= '0;
      prot_q        <= PROT_DATA;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      instruction_q <= '0;
      load_data_q   <= '0;
      instr_valid_q <= 1'b0;
      rw_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      req_q         <= req_d;
      prot_q        <= prot_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      instruction_q <= instruction_d;
      load_data_q   <= load_data_d;
      instr_valid_q <= instr_valid_d;
      rw_valid_q    <= rw_valid_d;
    end
  end

  assign M_AXI_AWVALID     = awvalid_q;
  assign M_AXI_AWADDR      = req_q.addr;
  assign M_AXI_AWPROT      = PROT_DATA;
  assign M_AXI_WVALID      = wvalid_q;
  assign M_AXI_WDATA       = req_q.data;
  assign M_AXI_WSTRB       = req_q.strb;
  assign M_AXI_BREADY      = bready_q;
  assign M_AXI_ARVALID     = arvalid_q;
  assign M_AXI_ARADDR      = req_q.addr;
  assign M_AXI_ARPROT      = prot_q;
  assign M_AXI_RREADY      = rready_q;
  assign instruction       = instruction_q;
  assign instruction_valid = instr_valid_q;
  assign load_data         = load_data_q;
  assign read_write_valid  = rw_valid_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: fetch, delayed load, split-handshake store, priority, reset.
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0] M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0] M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic [31:0] read_write_addr;
  logic [31:0] store_data;
  logic [3:0]  store_strobe;
  logic        read_enable, write_enable;
  logic [31:0] load_data;
  logic        read_write_valid;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  memory_arbiter dut (
    .CLK(CLK), .RSTn(RSTn),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .pc(pc), .pc_valid(pc_valid),
    .instruction(instruction), .instruction_valid(instruction_valid),
    .read_write_addr(read_write_addr), .store_data(store_data),
    .store_strobe(store_strobe), .read_enable(read_enable),
    .write_enable(write_enable), .load_data(load_data),
    .read_write_valid(read_write_valid)
  );

  // Advance one rising edge and settle before sampling or driving
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    RSTn = 1'b0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 2'b00;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    pc = '0; pc_valid = 0; read_write_addr = '0; store_data = '0; store_strobe = '0;
    read_enable = 0; write_enable = 0;

    // Reset
    tick(); tick();
    chk("rst_arvalid", 32'(M_AXI_ARVALID), 0);
    chk("rst_awvalid", 32'(M_AXI_AWVALID), 0);
    chk("rst_rready", 32'(M_AXI_RREADY), 0);
    chk("rst_ivalid", 32'(instruction_valid), 0);
    chk("rst_rwvalid", 32'(read_write_valid), 0);
    chk("rst_instr", instruction, 0);
    RSTn = 1'b1;
    tick();
    chk("idle_arvalid", 32'(M_AXI_ARVALID), 0);

    // Fetch with single-cycle ARREADY
    pc = 32'habac; pc_valid = 1;
    tick();
    chk("f_arvalid", 32'(M_AXI_ARVALID), 1);
    chk("f_araddr", M_AXI_ARADDR, 32'habac);
    chk("f_arprot", 32'(M_AXI_ARPROT), 32'h4);
    M_AXI_ARREADY = 1;
    tick();
    chk("f_arvalid_drop", 32'(M_AXI_ARVALID), 0);
    chk("f_rready", 32'(M_AXI_RREADY), 1);
    M_AXI_ARREADY = 0; M_AXI_RVALID = 1; M_AXI_RDATA = 32'hdeadaaaa;
    tick();
    chk("f_rready_drop", 32'(M_AXI_RREADY), 0);
    chk("f_ivalid", 32'(instruction_valid), 1);
    chk("f_instr", instruction, 32'hdeadaaaa);
    chk("f_rwvalid", 32'(read_write_valid), 0);
    M_AXI_RVALID = 0; pc_valid = 0;
    tick();
    chk("f_ivalid_pulse", 32'(instruction_valid), 0);
    chk("f_instr_hold", instruction, 32'hdeadaaaa);

    // Load with ARREADY held off for 3 cycles; address changes must not leak
    read_write_addr = 32'h200; read_enable = 1;
    tick();
    chk("l_arvalid", 32'(M_AXI_ARVALID), 1);
    chk("l_arprot", 32'(M_AXI_ARPROT), 0);
    read_write_addr = 32'h999;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("l_arvalid_hold", 32'(M_AXI_ARVALID), 1);
      chk("l_araddr_hold", M_AXI_ARADDR, 32'h200);
    end
    M_AXI_ARREADY = 1;
    tick();
    chk("l_rready", 32'(M_AXI_RREADY), 1);
    M_AXI_ARREADY = 0; M_AXI_RVALID = 1; M_AXI_RDATA = 32'h12345678;
    tick();
    chk("l_rwvalid", 32'(read_write_valid), 1);
    chk("l_data", load_data, 32'h12345678);
    chk("l_ivalid", 32'(instruction_valid), 0);
    chk("l_instr_kept", instruction, 32'hdeadaaaa);
    M_AXI_RVALID = 0; read_enable = 0;
    tick();
    chk("l_rwvalid_pulse", 32'(read_write_valid), 0);

    // Store; WREADY arrives two cycles after AWREADY
    read_write_addr = 32'h100; store_data = 32'hcafef00d; store_strobe = 4'b0011; write_enable = 1;
    tick();
    chk("s_awvalid", 32'(M_AXI_AWVALID), 1);
    chk("s_wvalid", 32'(M_AXI_WVALID), 1);
    chk("s_awaddr", M_AXI_AWADDR, 32'h100);
    chk("s_wdata", M_AXI_WDATA, 32'hcafef00d);
    chk("s_wstrb", 32'(M_AXI_WSTRB), 32'h3);
    chk("s_awprot", 32'(M_AXI_AWPROT), 0);
    chk("s_arvalid", 32'(M_AXI_ARVALID), 0);
    M_AXI_AWREADY = 1;
    tick();
    chk("s_awvalid_drop", 32'(M_AXI_AWVALID), 0);
    chk("s_wvalid_held", 32'(M_AXI_WVALID), 1);
    chk("s_bready_early", 32'(M_AXI_BREADY), 0);
    M_AXI_AWREADY = 0;
    tick();
    chk("s_wvalid_held2", 32'(M_AXI_WVALID), 1);
    chk("s_bready_early2", 32'(M_AXI_BREADY), 0);
    M_AXI_WREADY = 1;
    tick();
    chk("s_wvalid_drop", 32'(M_AXI_WVALID), 0);
    chk("s_bready", 32'(M_AXI_BREADY), 1);
    M_AXI_WREADY = 0; M_AXI_BVALID = 1;
    tick();
    chk("s_bready_drop", 32'(M_AXI_BREADY), 0);
    chk("s_rwvalid", 32'(read_write_valid), 1);
    chk("s_load_kept", load_data, 32'h12345678);
    M_AXI_BVALID = 0; write_enable = 0;
    tick();
    chk("s_rwvalid_pulse", 32'(read_write_valid), 0);

    // Fetch and load together: load wins, fetch follows after DONE
    pc = 32'h300; pc_valid = 1; read_write_addr = 32'h400; read_enable = 1;
    tick();
    chk("p_araddr_load", M_AXI_ARADDR, 32'h400);
    chk("p_arprot_load", 32'(M_AXI_ARPROT), 0);
    M_AXI_ARREADY = 1;
    tick();
    M_AXI_ARREADY = 0; M_AXI_RVALID = 1; M_AXI_RDATA = 32'h11111111;
    tick();
    chk("p_rwvalid", 32'(read_write_valid), 1);
    chk("p_ivalid", 32'(instruction_valid), 0);
    chk("p_load", load_data, 32'h11111111);
    M_AXI_RVALID = 0; read_enable = 0;
    tick();
    chk("p_done_no_sample", 32'(M_AXI_ARVALID), 0);
    tick();
    chk("p_fetch_arvalid", 32'(M_AXI_ARVALID), 1);
    chk("p_fetch_araddr", M_AXI_ARADDR, 32'h300);
    chk("p_fetch_arprot", 32'(M_AXI_ARPROT), 32'h4);
    M_AXI_ARREADY = 1;
    tick();
    M_AXI_ARREADY = 0;
    tick();
    chk("p_rd_data_wait", 32'(M_AXI_RREADY), 1);

    // Asynchronous reset in RD_DATA clears everything immediately
    RSTn = 1'b0;
    #1;
    chk("ar_rready", 32'(M_AXI_RREADY), 0);
    chk("ar_arvalid", 32'(M_AXI_ARVALID), 0);
    chk("ar_instr", instruction, 0);
    chk("ar_load", load_data, 0);
    chk("ar_araddr", M_AXI_ARADDR, 0);
    pc_valid = 0;
    tick();
    RSTn = 1'b1;
    tick();
    chk("ar_idle", 32'(M_AXI_ARVALID), 0);

    // Load and store together are treated as a store
    read_write_addr = 32'h500; store_data = 32'h0badf00d; store_strobe = 4'hf;
    read_enable = 1; write_enable = 1;
    tick();
    chk("b_awvalid", 32'(M_AXI_AWVALID), 1);
    chk("b_arvalid", 32'(M_AXI_ARVALID), 0);
    M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
    tick();
    chk("b_bready", 32'(M_AXI_BREADY), 1);
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 1; M_AXI_BRESP = 2'b10;
    tick();
    chk("b_rwvalid", 32'(read_write_valid), 1);
    M_AXI_BVALID = 0; read_enable = 0; write_enable = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
